// File: rtl/rv32_core.sv
// Single-cycle RV32I ALU-subset core: fetch, decode, execute and write back in one clock.
// Define CORE_SHIFT_EN to build SLL/SRL/SRA (and immediate forms); otherwise those encodings are NOPs.

module rv32_regfile #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr_a_i,
    input  logic [4:0]      raddr_b_i,
    output logic [XLEN-1:0] rdata_a_c_o,
    output logic [XLEN-1:0] rdata_b_c_o
);

    // Storage is deliberately not reset so externally preloaded contents survive reset.
    logic [XLEN-1:0] REGS [0:31];

    always_ff @(posedge clk) begin
        if (we_i && (waddr_i != 5'd0)) begin
            REGS[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_c_o = (raddr_a_i == 5'd0) ? '0 : REGS[raddr_a_i];
    assign rdata_b_c_o = (raddr_b_i == 5'd0) ? '0 : REGS[raddr_b_i];

endmodule

module rv32_core #(
    parameter int unsigned INST_W      = 32,
    parameter int unsigned INST_ADDR_W = 10,
    parameter int unsigned XLEN        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [INST_W-1:0]      progmem_data,
    output logic [INST_ADDR_W-1:0] progmem_addr
);

    localparam logic [6:0] OPCODE_ALUR = 7'b0110011;
    localparam logic [6:0] OPCODE_ALUI = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI  = 7'b0110111;

    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0]      inst;
    logic [6:0]             opcode;
    logic [4:0]             rd, rs1, rs2;
    logic [2:0]             funct3;
    logic [XLEN-1:0]        imm, op_a, op_b, rs2_data;
    logic [XLEN-1:0]        result_c;
    logic                   wr_en_c;
    logic                   is_alu, is_alui;

    assign inst    = progmem_data;
    assign opcode  = inst[6:0];
    assign rd      = inst[11:7];
    assign funct3  = inst[14:12];
    assign rs1     = inst[19:15];
    assign rs2     = inst[24:20];
    assign imm     = XLEN'($signed(inst[31:20]));
    assign is_alui = (opcode == OPCODE_ALUI);
    assign is_alu  = (opcode == OPCODE_ALUR) || is_alui;
    assign op_b    = is_alui ? imm : rs2_data;

    rv32_regfile #(.XLEN(XLEN)) regfile (
        .clk         (clk),
        .we_i        (wr_en_c && en),
        .waddr_i     (rd),
        .wdata_i     (result_c),
        .raddr_a_i   (rs1),
        .raddr_b_i   (rs2),
        .rdata_a_c_o (op_a),
        .rdata_b_c_o (rs2_data)
    );

    // Execute: result and write enable; unsupported encodings leave wr_en_c low.
    always_comb begin
        result_c = '0;
        wr_en_c  = 1'b0;
        if (is_alu) begin
            case (funct3)
                3'b000: begin
                    // Only the register form subtracts; inst[30] in ADDI is an immediate bit.
                    result_c = (!is_alui && inst[30]) ? (op_a - op_b) : (op_a + op_b);
                    wr_en_c  = 1'b1;
                end
                3'b111: begin
                    result_c = op_a & op_b;
                    wr_en_c  = 1'b1;
                end
                3'b110: begin
                    result_c = op_a | op_b;
                    wr_en_c  = 1'b1;
                end
                3'b100: begin
                    result_c = op_a ^ op_b;
                    wr_en_c  = 1'b1;
                end
                3'b010: begin
                    result_c = XLEN'($signed(op_a) < $signed(op_b));
                    wr_en_c  = 1'b1;
                end
                3'b011: begin
                    result_c = XLEN'(op_a < op_b);
                    wr_en_c  = 1'b1;
                end
`ifdef CORE_SHIFT_EN
                3'b001: begin
                    result_c = op_a << op_b[4:0];
                    wr_en_c  = 1'b1;
                end
                3'b101: begin
                    result_c = inst[30] ? XLEN'($signed(op_a) >>> op_b[4:0])
                                        : (op_a >> op_b[4:0]);
                    wr_en_c  = 1'b1;
                end
`endif
                default: begin
                    result_c = '0;
                    wr_en_c  = 1'b0;
                end
            endcase
        end else if (opcode == OPCODE_LUI) begin
            result_c = XLEN'({inst[31:12], 12'b0});
            wr_en_c  = 1'b1;
        end
    end

    // PC advances one word per enabled cycle, wrapping naturally.
    always_comb begin
        pc_d = pc_q;
        if (en) begin
            pc_d = pc_q + INST_ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign progmem_addr = pc_q;

endmodule

// File: tb/tb_rv32_core.sv
// Directed bench for rv32_core: hand-assembled program, register and PC checks after each step.

module tb_rv32_core;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] progmem_data;
    logic [9:0]  progmem_addr;
    logic [31:0] mem [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    rv32_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .progmem_data (progmem_data),
        .progmem_addr (progmem_addr)
    );

    assign progmem_data = mem[progmem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] lui(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] rv(input int i);
        return dut.regfile.REGS[i];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] x8_exp;
`ifdef CORE_SHIFT_EN
        x8_exp = 32'd192;
`else
        x8_exp = 32'd55;
`endif
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]  = i_t(12'd12, 5'd0, 3'b000, 5'd1);
        mem[1]  = i_t(12'd100, 5'd0, 3'b000, 5'd2);
        mem[2]  = i_t(12'd2, 5'd0, 3'b000, 5'd0);
        mem[3]  = r_t(7'h00, 5'd1, 5'd0, 3'b000, 5'd11);
        mem[4]  = i_t(12'd10, 5'd0, 3'b000, 5'd2);
        mem[5]  = i_t(12'd11, 5'd1, 3'b000, 5'd2);
        mem[6]  = r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd2);
        mem[7]  = r_t(7'h00, 5'd2, 5'd1, 3'b111, 5'd2);
        mem[8]  = i_t(12'hFFF, 5'd0, 3'b000, 5'd3);
        mem[9]  = r_t(7'h20, 5'd3, 5'd0, 3'b000, 5'd4);
        mem[10] = r_t(7'h00, 5'd0, 5'd3, 3'b010, 5'd5);
        mem[11] = r_t(7'h00, 5'd0, 5'd3, 3'b011, 5'd6);
        mem[12] = lui(20'hABCDE, 5'd7);
        mem[13] = i_t(12'd55, 5'd0, 3'b000, 5'd8);
        mem[14] = 32'h0000_047F;
        mem[15] = i_t(12'd4, 5'd1, 3'b001, 5'd8);
        mem[16] = i_t(12'h0F0, 5'd1, 3'b100, 5'd9);
        mem[17] = i_t(12'd3, 5'd1, 3'b110, 5'd10);
        mem[18] = i_t(12'h800, 5'd0, 3'b000, 5'd12);
        mem[19] = i_t(12'd0, 5'd3, 3'b010, 5'd13);
        mem[20] = i_t(12'hFFF, 5'd1, 3'b011, 5'd14);
        mem[21] = r_t(7'h00, 5'd3, 5'd3, 3'b000, 5'd15);
        mem[22] = i_t(12'h400, 5'd1, 3'b000, 5'd16);

        rst_n = 1'b0;
        en    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", 32'(progmem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step(); chk("pc_1", 32'(progmem_addr), 32'd1); chk("x1_preload", rv(1), 32'd12);
        step(); chk("pc_2", 32'(progmem_addr), 32'd2); chk("x2_preload", rv(2), 32'd100);
        step(); chk("pc_3", 32'(progmem_addr), 32'd3);
        step(); chk("x0_reads_zero", rv(11), 32'd12);
        step(); chk("addi_x2_10", rv(2), 32'd10);
        step(); chk("addi_x2_23", rv(2), 32'd23);
        step(); chk("add_x2_35", rv(2), 32'd35);
        step(); chk("and_x2_0", rv(2), 32'd0);
        step(); chk("addi_neg1", rv(3), 32'hFFFF_FFFF);
        step(); chk("sub_x4", rv(4), 32'd1); chk("pc_10", 32'(progmem_addr), 32'd10);

        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc", 32'(progmem_addr), 32'd10);
            chk("stall_x4", rv(4), 32'd1);
            chk("stall_x3", rv(3), 32'hFFFF_FFFF);
        end
        en = 1'b1;

        step(); chk("slt_x5", rv(5), 32'd1); chk("resume_pc", 32'(progmem_addr), 32'd11);
        step(); chk("sltu_x6", rv(6), 32'd0);
        step(); chk("lui_x7", rv(7), 32'hABCD_E000);
        step(); chk("addi_x8_55", rv(8), 32'd55);
        step(); chk("unknown_nop_x8", rv(8), 32'd55); chk("unknown_pc", 32'(progmem_addr), 32'd15);
        step(); chk("slli_x8", rv(8), x8_exp);
        step(); chk("xori_x9", rv(9), 32'd252);
        step(); chk("ori_x10", rv(10), 32'd15);
        step(); chk("addi_min_imm", rv(12), 32'hFFFF_F800);
        step(); chk("slti_x13", rv(13), 32'd1);
        step(); chk("sltiu_x14", rv(14), 32'd1);
        step(); chk("add_wrap_x15", rv(15), 32'hFFFF_FFFE);
        step(); chk("addi_bit30_x16", rv(16), 32'd1036);

        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_pc", 32'(progmem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(); chk("post_reset_pc", 32'(progmem_addr), 32'd1); chk("post_reset_x1", rv(1), 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
